// File: rtl/i2s_pkg.sv
// Shared I2S types: receive FSM states and the default
// channel word width used by the audio-in and audio-out blocks.
package i2s_pkg;

  localparam int unsigned SAMPLE_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    L_SKIP,
    L_SHIFT,
    L_WAIT,
    R_SKIP,
    R_SHIFT,
    R_WAIT
  } i2s_state_e;

endpackage

// File: rtl/i2s_audio_in_if.sv
// Sample pair handshake between the I2S receiver and its consumer.
// master: samples, valid, overrun, frame_err out; ready in.
interface i2s_audio_in_if
  import i2s_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEF
);

  logic [SAMPLE_WIDTH-1:0] left_sample_o;
  logic [SAMPLE_WIDTH-1:0] right_sample_o;
  logic                    sample_valid_o;
  logic                    sample_ready_i;
  logic                    overrun_o;
  logic                    frame_err_o;

  modport master (
    output left_sample_o,
    output right_sample_o,
    output sample_valid_o,
    output overrun_o,
    output frame_err_o,
    input  sample_ready_i
  );

  modport slave (
    input  left_sample_o,
    input  right_sample_o,
    input  sample_valid_o,
    input  overrun_o,
    input  frame_err_o,
    output sample_ready_i
  );

endinterface

// File: rtl/i2s_audio_in_sync_edge_detect.sv
// Pin synchronizer with rise/fall detect on the synced level.
// Ports: clk_i, rst_i, async_i in; sync_o, rise_o, fall_o out.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_i};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign sync_o = r_sync[SYNC_STAGES-1];
  assign rise_o = sync_o & ~r_prev;
  assign fall_o = ~sync_o & r_prev;

endmodule

// File: rtl/i2s_audio_in.sv
// I2S capture from the AIC23B ADC: oversampled pins, L/R word
// FSM and a valid/ready pair holding register.
// Ports: clk_i, rst_i, bclk_i, lrclk_i, data_i; bus (master).
module i2s_audio_in
  import i2s_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           bclk_i,
  input  logic           lrclk_i,
  input  logic           data_i,
  i2s_audio_in_if.master bus
);

  localparam int unsigned CW = $clog2(SAMPLE_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_WIDTH - 1);

  logic w_bclk_sync, w_bclk_rise, w_bclk_fall;
  logic w_lr_sync, w_lr_rise, w_lr_fall;
  logic w_data, w_data_rise, w_data_fall;
  logic w_unused;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_bclk (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .async_i(bclk_i),
    .sync_o (w_bclk_sync),
    .rise_o (w_bclk_rise),
    .fall_o (w_bclk_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_lr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .async_i(lrclk_i),
    .sync_o (w_lr_sync),
    .rise_o (w_lr_rise),
    .fall_o (w_lr_fall)
  );

  // Same depth as bclk so each bit lines up with its edge.
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_data (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .async_i(data_i),
    .sync_o (w_data),
    .rise_o (w_data_rise),
    .fall_o (w_data_fall)
  );

  assign w_unused = ^{w_bclk_sync, w_bclk_fall, w_lr_sync,
                      w_data_rise, w_data_fall};

  i2s_state_e              r_state;
  logic [SAMPLE_WIDTH-1:0] r_shift;
  logic [CW-1:0]           r_cnt;
  logic [SAMPLE_WIDTH-1:0] r_left;
  logic [SAMPLE_WIDTH-1:0] r_right;
  logic                    r_pair;
  logic                    r_ferr;

  logic [SAMPLE_WIDTH-1:0] w_next;
  logic                    w_last;

  assign w_next = {r_shift[SAMPLE_WIDTH-2:0], w_data};
  assign w_last = (r_cnt == LAST);

  // An lrclk edge wins over a coincident bclk_rise; that rise
  // is then the skipped one, so go straight to SHIFT.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_left  <= '0;
      r_right <= '0;
      r_pair  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_pair <= 1'b0;
      r_ferr <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_lr_fall) begin
            r_state <= w_bclk_rise ? L_SHIFT : L_SKIP;
            r_cnt   <= '0;
          end
        end
        L_SKIP: begin
          if (w_lr_rise) begin
            r_ferr  <= 1'b1;
            r_state <= IDLE;
          end else if (w_bclk_rise) begin
            r_state <= L_SHIFT;
            r_cnt   <= '0;
          end
        end
        L_SHIFT: begin
          if (w_lr_rise) begin
            r_ferr  <= 1'b1;
            r_state <= IDLE;
          end else if (w_bclk_rise) begin
            r_shift <= w_next;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
              r_left  <= w_next;
              r_state <= L_WAIT;
            end
          end
        end
        L_WAIT: begin
          if (w_lr_rise) begin
            r_state <= w_bclk_rise ? R_SHIFT : R_SKIP;
            r_cnt   <= '0;
          end
        end
        R_SKIP: begin
          if (w_lr_fall) begin
            r_ferr  <= 1'b1;
            r_state <= w_bclk_rise ? L_SHIFT : L_SKIP;
            r_cnt   <= '0;
          end else if (w_bclk_rise) begin
            r_state <= R_SHIFT;
            r_cnt   <= '0;
          end
        end
        R_SHIFT: begin
          if (w_lr_fall) begin
            r_ferr  <= 1'b1;
            r_state <= w_bclk_rise ? L_SHIFT : L_SKIP;
            r_cnt   <= '0;
          end else if (w_bclk_rise) begin
            r_shift <= w_next;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
              r_right <= w_next;
              r_pair  <= 1'b1;
              r_state <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (w_lr_fall) begin
            r_state <= w_bclk_rise ? L_SHIFT : L_SKIP;
            r_cnt   <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  logic [SAMPLE_WIDTH-1:0] r_hold_l;
  logic [SAMPLE_WIDTH-1:0] r_hold_r;
  logic                    r_valid;
  logic                    r_ovr;

  // A full holder keeps its pair; a fresh pair is dropped
  // unless the held one leaves on this same edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hold_l <= '0;
      r_hold_r <= '0;
      r_valid  <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (r_pair) begin
        if (!r_valid || bus.sample_ready_i) begin
          r_hold_l <= r_left;
          r_hold_r <= r_right;
          r_valid  <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && bus.sample_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.left_sample_o  = r_hold_l;
  assign bus.right_sample_o = r_hold_r;
  assign bus.sample_valid_o = r_valid;
  assign bus.overrun_o      = r_ovr;
  assign bus.frame_err_o    = r_ferr;

endmodule

// File: tb/tb_i2s_audio_in.sv
// Bench for i2s_audio_in: frame-level pin driver plus a
// word-level model of pair delivery and error pulses.
module tb_i2s_audio_in;

  logic clk;
  logic rst = 1'b0;
  logic bclk, lrclk, data;

  i2s_audio_in_if #(.SAMPLE_WIDTH(16)) bus ();

  i2s_audio_in #(
    .SAMPLE_WIDTH(16),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bclk_i (bclk),
    .lrclk_i(lrclk),
    .data_i (data),
    .bus    (bus)
  );

  typedef struct {
    int          t;
    logic [15:0] l;
    logic [15:0] r;
  } arr_t;

  arr_t        arr_q[$];
  int          err_q[$];
  logic [31:0] acc_q[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int rmode = 0;
  int pulse_at = -1;
  int lsb_cyc = 0;
  int rise_cyc = 0;
  int ovr_cnt = 0;
  int err_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Consumer ready: off, on, random, or a single-cycle pulse
  // landing on the edge where the next pair reaches the holder.
  initial begin
    bus.sample_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      bus.sample_ready_i = (rmode == 1) ||
        (rmode == 2 && $urandom_range(0, 1) == 1) ||
        (rmode == 3 && cyc + 1 == pulse_at);
    end
  end

  // Model: a complete frame reaches the holder 4 clk edges after
  // the pin edge of its right LSB; a mid-word lrclk edge pulses
  // frame_err 3 edges after it.
  initial begin
    bit          rdy, rst_s, arr, eerr, dv, prev_v;
    bit          mv, movr;
    logic [15:0] ml, mr, nl, nr;
    mv = 0; movr = 0; ml = 0; mr = 0; prev_v = 0;
    nl = 0; nr = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      rdy = bus.sample_ready_i;
      rst_s = rst;
      dv = bus.sample_valid_o;
      if (dv && rdy && !rst_s)
        acc_q.push_back({bus.left_sample_o, bus.right_sample_o});
      arr = 0;
      if (arr_q.size() > 0 && arr_q[0].t == cyc) begin
        arr = 1;
        nl = arr_q[0].l;
        nr = arr_q[0].r;
        void'(arr_q.pop_front());
      end
      eerr = 0;
      if (err_q.size() > 0 && err_q[0] == cyc) begin
        eerr = 1;
        void'(err_q.pop_front());
      end
      if (rst_s) begin
        mv = 0; movr = 0; ml = 0; mr = 0; eerr = 0;
        arr_q.delete();
        err_q.delete();
      end else if (arr) begin
        if (!mv || rdy) begin
          ml = nl; mr = nr; mv = 1; movr = 0;
        end else begin
          movr = 1;
        end
      end else begin
        movr = 0;
        if (mv && rdy) mv = 0;
      end
      #1;
      chk("model",
          {bus.sample_valid_o, bus.overrun_o, bus.frame_err_o,
           bus.left_sample_o, bus.right_sample_o},
          {mv, movr, eerr, ml, mr});
      if (bus.overrun_o) ovr_cnt++;
      if (bus.frame_err_o) err_cnt++;
      if (bus.sample_valid_o && !prev_v) rise_cyc = cyc;
      prev_v = bus.sample_valid_o;
    end
  end

  // One channel slot of len bclk periods, h clk per half period.
  // Rise 0 is the I2S delay bit; rises 1..16 carry MSB..LSB.
  task automatic drive_slot(input bit lr, input logic [15:0] w,
                            input int len, input int h,
                            input bit coin, input int rst_bit,
                            input bit is_right, input bit ok,
                            input logic [15:0] lw,
                            input bit mark_err);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      bclk = 1'b0;
      if (k == 0 && !coin) lrclk = lr;
      if (k == 0 && mark_err) err_q.push_back(cyc + 3);
      data = (k >= 1 && k <= 16) ? w[16-k] : 1'($urandom);
      repeat (h - 1) @(negedge clk);
      @(negedge clk);
      bclk = 1'b1;
      if (k == 0 && coin) lrclk = lr;
      if (is_right && k == 16 && ok) begin
        arr_q.push_back('{cyc + 4, lw, w});
        lsb_cyc = cyc;
        pulse_at = cyc + 4;
      end
      if (is_right && k == rst_bit) begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out",
            {bus.sample_valid_o, bus.left_sample_o,
             bus.right_sample_o}, 64'h0);
        rst = 1'b0;
      end
      repeat (h - 1) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [15:0] l,
                            input logic [15:0] r,
                            input int h, input int slot,
                            input int lbits, input int rst_bit,
                            input bit coin);
    bit ok;
    bit trunc;
    ok = (lbits == 16) && (rst_bit < 0);
    trunc = (lbits < 16);
    drive_slot(1'b0, l, trunc ? lbits + 1 : slot, h, coin,
               -1, 1'b0, 1'b0, 16'h0, 1'b0);
    drive_slot(1'b1, r, slot, h, 1'b0, rst_bit, 1'b1, ok,
               l, trunc);
  endtask

  initial begin
    int n0;
    bclk = 1'b0;
    lrclk = 1'b0;
    data = 1'b0;
    #2 rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_out",
        {bus.sample_valid_o, bus.overrun_o, bus.frame_err_o,
         bus.left_sample_o, bus.right_sample_o}, 64'h0);
    rst = 1'b0;

    rmode = 1;
    drive_slot(1'b1, 16'h0, 4, 4, 1'b0, -1, 1'b0, 1'b0,
               16'h0, 1'b0);
    repeat (3) send_frame(16'hA5C3, 16'h1234, 8, 18, 16, -1, 0);
    repeat (6) @(negedge clk);
    chk("clean_count", acc_q.size(), 3);
    chk("clean_pair", acc_q[$], 32'hA5C31234);
    chk("latency", rise_cyc - lsb_cyc, 4);

    rmode = 0;
    send_frame(16'h0001, 16'h0002, 8, 18, 16, -1, 0);
    send_frame(16'h0003, 16'h0004, 8, 18, 16, -1, 0);
    repeat (6) @(negedge clk);
    chk("bp_hold",
        {bus.sample_valid_o, bus.left_sample_o,
         bus.right_sample_o}, {1'b1, 16'h0001, 16'h0002});
    chk("bp_overrun", ovr_cnt, 1);
    rmode = 1;
    send_frame(16'h0005, 16'h0006, 8, 18, 16, -1, 0);
    repeat (6) @(negedge clk);
    chk("bp_old", acc_q[acc_q.size()-2], 32'h00010002);
    chk("bp_next", acc_q[$], 32'h00050006);

    rmode = 0;
    send_frame(16'h1111, 16'h2222, 8, 18, 16, -1, 0);
    rmode = 3;
    send_frame(16'h3333, 16'h4444, 8, 18, 16, -1, 0);
    repeat (6) @(negedge clk);
    chk("sim_load",
        {bus.sample_valid_o, bus.left_sample_o,
         bus.right_sample_o}, {1'b1, 16'h3333, 16'h4444});
    chk("sim_no_ovr", ovr_cnt, 1);
    rmode = 1;
    repeat (4) @(negedge clk);
    chk("sim_first", acc_q[acc_q.size()-2], 32'h11112222);
    chk("sim_second", acc_q[$], 32'h33334444);

    n0 = acc_q.size();
    send_frame(16'h1357, 16'h2468, 8, 18, 7, -1, 0);
    send_frame(16'hBEEF, 16'hCAFE, 8, 18, 16, -1, 0);
    repeat (6) @(negedge clk);
    chk("err_count", err_cnt, 1);
    chk("err_pairs", acc_q.size() - n0, 1);
    chk("err_next", acc_q[$], 32'hBEEFCAFE);

    n0 = acc_q.size();
    send_frame(16'h5555, 16'h6666, 8, 18, 16, 5, 0);
    send_frame(16'h7777, 16'h8888, 8, 18, 16, -1, 0);
    repeat (6) @(negedge clk);
    chk("rst_pairs", acc_q.size() - n0, 1);
    chk("rst_next", acc_q[$], 32'h77778888);

    send_frame(16'h8001, 16'h7FFE, 8, 18, 16, -1, 1);
    repeat (6) @(negedge clk);
    chk("coin", acc_q[$], 32'h80017FFE);

    rmode = 2;
    repeat (20)
      send_frame(16'($urandom), 16'($urandom),
                 $urandom_range(2, 8), $urandom_range(17, 20),
                 16, -1, 0);
    rmode = 1;
    repeat (40) @(negedge clk);
    chk("final_err", err_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
